smpl_cmp_checker: RTL and testbench

- Upstream feeder of the NIOS sample-compare status PIO. Checks received LMS7 IQ samples against a known two-word alternating test pattern.
- Produces a 2-bit status {error, done}. The PIO samples this status, and firmware polls it.
- Firmware arms the check through a control PIO bit (cmp_start) and sets the sample count (cmp_length).

---
 rtl/smpl_cmp_checker.sv | 147 ++++++++++++++
 tb/tb_smpl_cmp_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/smpl_cmp_checker.sv
// ============================================================================
// smpl_cmp_checker
//   Compares received IQ samples against a two-word alternating test pattern.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module smpl_cmp_checker #(
  parameter int IQ_W         = 12,
  parameter int CNT_W        = 16,
  parameter int SYNC_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmp_start,
  input  logic [CNT_W-1:0] cmp_length,
  input  logic [IQ_W-1:0]  exp_i0,
  input  logic [IQ_W-1:0]  exp_q0,
  input  logic [IQ_W-1:0]  exp_i1,
  input  logic [IQ_W-1:0]  exp_q1,
  input  logic             smpl_valid,
  input  logic [IQ_W-1:0]  smpl_i,
  input  logic [IQ_W-1:0]  smpl_q,
  output logic [1:0]       cmp_status,
  output logic [CNT_W-1:0] cmp_err_cnt,
  output logic             busy
);

  localparam int TMO_W = (SYNC_TIMEOUT < 2) ? 1 : $clog2(SYNC_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SYNC_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_q;
  logic             cmp_start_q;
  logic             arm_ok_q;
  logic             parity_q;
  logic             err_flag_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] smpl_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       status_q;

  logic             start_rise;
  logic             sync_hit;
  logic             mismatch;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic [TMO_W-1:0] tmo_inc;

  assign start_rise = cmp_start & ~cmp_start_q;
  assign sync_hit   = (smpl_i == exp_i0) && (smpl_q == exp_q0);
  assign mismatch   = parity_q ? ((smpl_i != exp_i1) || (smpl_q != exp_q1))
                               : ((smpl_i != exp_i0) || (smpl_q != exp_q0));
  assign len_eff    = (len_q == '0) ? CNT_ONE : len_q;
  assign cnt_inc    = smpl_cnt_q + CNT_ONE;
  assign tmo_inc    = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmp_start_q <= 1'b0;
      arm_ok_q    <= 1'b0;
      parity_q    <= 1'b0;
      err_flag_q  <= 1'b0;
      len_q       <= '0;
      smpl_cnt_q  <= '0;
      err_cnt_q   <= '0;
      tmo_q       <= '0;
      status_q    <= 2'b00;
    end else begin
      cmp_start_q <= cmp_start;
      // A start level still high across reset is not a fresh request; wait for it to drop.
      if (!cmp_start) arm_ok_q <= 1'b1;

      if (!cmp_start) begin
        state_q   <= ST_IDLE;
        status_q  <= 2'b00;
        err_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_rise && arm_ok_q) begin
              state_q    <= ST_SYNC;
              len_q      <= cmp_length;
              smpl_cnt_q <= '0;
              tmo_q      <= '0;
              parity_q   <= 1'b0;
              err_flag_q <= 1'b0;
              err_cnt_q  <= '0;
              status_q   <= 2'b00;
            end
          end
          ST_SYNC: begin
            if (smpl_valid && sync_hit) begin
              smpl_cnt_q <= CNT_ONE;
              parity_q   <= 1'b1;
              if (len_eff == CNT_ONE) begin
                state_q  <= ST_DONE;
                status_q <= 2'b01;
              end else begin
                state_q  <= ST_COMPARE;
              end
            end else begin
              tmo_q <= tmo_inc;
              if (tmo_inc == TMO_LAST) begin
                state_q  <= ST_DONE;
                status_q <= 2'b11;
              end
            end
          end
          ST_COMPARE: begin
            if (smpl_valid) begin
              parity_q   <= ~parity_q;
              smpl_cnt_q <= cnt_inc;
              if (mismatch) begin
                err_flag_q <= 1'b1;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_ONE;
              end
              if (cnt_inc == len_eff) begin
                state_q  <= ST_DONE;
                status_q <= {err_flag_q | mismatch, 1'b1};
              end
            end
          end
          default: begin
            state_q <= ST_DONE;
          end
        endcase
      end
    end
  end

  assign cmp_status  = status_q;
  assign cmp_err_cnt = err_cnt_q;
  assign busy        = (state_q == ST_SYNC) || (state_q == ST_COMPARE);

endmodule

`default_nettype wire

// File: tb/tb_smpl_cmp_checker.sv
// ============================================================================
// tb_smpl_cmp_checker
//   Directed self-checking bench for smpl_cmp_checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_smpl_cmp_checker;

  localparam int IQ_W  = 12;
  localparam int CNT_W = 16;

  localparam logic [IQ_W-1:0] P0I = 12'hAAA;
  localparam logic [IQ_W-1:0] P0Q = 12'h555;
  localparam logic [IQ_W-1:0] P1I = 12'h555;
  localparam logic [IQ_W-1:0] P1Q = 12'hAAA;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmp_start;
  logic [CNT_W-1:0] cmp_length;
  logic [IQ_W-1:0]  exp_i0, exp_q0, exp_i1, exp_q1;
  logic             smpl_valid;
  logic [IQ_W-1:0]  smpl_i, smpl_q;
  logic [1:0]       cmp_status;
  logic [CNT_W-1:0] cmp_err_cnt;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  smpl_cmp_checker #(
    .IQ_W        (IQ_W),
    .CNT_W       (CNT_W),
    .SYNC_TIMEOUT(100)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .cmp_start  (cmp_start),
    .cmp_length (cmp_length),
    .exp_i0     (exp_i0),
    .exp_q0     (exp_q0),
    .exp_i1     (exp_i1),
    .exp_q1     (exp_q1),
    .smpl_valid (smpl_valid),
    .smpl_i     (smpl_i),
    .smpl_q     (smpl_q),
    .cmp_status (cmp_status),
    .cmp_err_cnt(cmp_err_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IQ_W-1:0] i, input logic [IQ_W-1:0] q);
    smpl_valid = 1'b1;
    smpl_i     = i;
    smpl_q     = q;
    tick();
    smpl_valid = 1'b0;
    smpl_i     = 12'h000;
    smpl_q     = 12'h000;
  endtask

  // Drop then raise cmp_start; DUT is in SYNC on return.
  task automatic arm(input logic [CNT_W-1:0] len);
    cmp_start  = 1'b0;
    tick();
    cmp_length = len;
    cmp_start  = 1'b1;
    tick();
  endtask

  task automatic send_pat(input int k, input logic [IQ_W-1:0] qxor);
    if (k % 2 == 0) send(P0I, P0Q ^ qxor);
    else            send(P1I, P1Q ^ qxor);
  endtask

  initial begin
    reset = 1'b1; cmp_start = 1'b0; cmp_length = '0;
    exp_i0 = P0I; exp_q0 = P0Q; exp_i1 = P1I; exp_q1 = P1Q;
    smpl_valid = 1'b0; smpl_i = '0; smpl_q = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_status", 32'(cmp_status), 32'h0);
    check("rst_errcnt", 32'(cmp_err_cnt), 32'h0);
    check("rst_busy",   32'(busy), 32'h0);

    // Clean pass, length 8, with leading junk
    arm(16'd8);
    check("clean_busy", 32'(busy), 32'h1);
    send(12'h123, 12'h456);
    send(12'h555, 12'h555);
    for (int k = 0; k < 7; k++) send_pat(k, 12'h000);
    check("clean_pre_done", 32'(cmp_status), 32'h0);
    send_pat(7, 12'h000);
    check("clean_status", 32'(cmp_status), 32'h1);
    check("clean_errcnt", 32'(cmp_err_cnt), 32'h0);
    check("clean_busy_off", 32'(busy), 32'h0);

    // Q corrupted on samples 3 and 6
    arm(16'd8);
    check("err_armed_status", 32'(cmp_status), 32'h0);
    for (int k = 0; k < 7; k++) send_pat(k, (k == 2 || k == 5) ? 12'h001 : 12'h000);
    check("err_pre_done", 32'(cmp_status), 32'h0);
    check("err_busy", 32'(busy), 32'h1);
    send_pat(7, 12'h000);
    check("err_status", 32'(cmp_status), 32'h3);
    check("err_errcnt", 32'(cmp_err_cnt), 32'h2);

    // Sync timeout after 100 SYNC cycles
    arm(16'd8);
    for (int c = 0; c < 99; c++) begin
      if (c % 10 == 0) begin smpl_valid = 1'b1; smpl_i = P1I; smpl_q = P1Q; end
      else smpl_valid = 1'b0;
      tick();
    end
    smpl_valid = 1'b0;
    check("tmo_pre_busy", 32'(busy), 32'h1);
    check("tmo_pre_status", 32'(cmp_status), 32'h0);
    tick();
    check("tmo_status", 32'(cmp_status), 32'h3);
    check("tmo_busy", 32'(busy), 32'h0);
    check("tmo_errcnt", 32'(cmp_err_cnt), 32'h0);

    // Abort after 3 of 8, then clean restart
    arm(16'd8);
    for (int k = 0; k < 3; k++) send_pat(k, 12'h000);
    cmp_start = 1'b0;
    tick();
    check("abort_status", 32'(cmp_status), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    cmp_start = 1'b1;
    tick();
    check("restart_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 8; k++) send_pat(k, 12'h000);
    check("restart_status", 32'(cmp_status), 32'h1);

    // Length 0 behaves as 1, with gaps before sync
    arm(16'd0);
    send(12'h111, 12'h222); tick(); tick();
    check("len0_busy", 32'(busy), 32'h1);
    send(P0I, P0Q);
    check("len0_status", 32'(cmp_status), 32'h1);

    arm(16'd1);
    send(P1I, P1Q); tick();
    send(P0I, P0Q);
    check("len1_status", 32'(cmp_status), 32'h1);

    // 1-in-3 valid; junk on the bus during gaps must not advance parity
    arm(16'd4);
    for (int k = 0; k < 4; k++) begin
      send_pat(k, 12'h000);
      if (k < 3) begin
        smpl_i = 12'hFFF; smpl_q = 12'hFFF; tick(); tick();
      end
    end
    check("gap_status", 32'(cmp_status), 32'h1);
    check("gap_errcnt", 32'(cmp_err_cnt), 32'h0);

    // Abort in the same cycle as the final sample
    arm(16'd2);
    send(P0I, P0Q);
    cmp_start = 1'b0;
    send(P1I, P1Q);
    check("abort_final_status", 32'(cmp_status), 32'h0);
    check("abort_final_busy", 32'(busy), 32'h0);

    // Reset mid-run with cmp_start held high
    arm(16'd8);
    send_pat(0, 12'h000);
    send_pat(1, 12'h010);
    send_pat(2, 12'h000);
    check("mid_errcnt", 32'(cmp_err_cnt), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_status", 32'(cmp_status), 32'h0);
    check("mid_rst_errcnt", 32'(cmp_err_cnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    for (int c = 0; c < 5; c++) tick();
    check("mid_no_restart", 32'(busy), 32'h0);
    arm(16'd8);
    check("mid_rearm_busy", 32'(busy), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
